// File: rtl/nt_emotion_pkg.sv
// Shared definitions for the neurotransmitter emotion evaluator:
// emotion indices, evaluator FSM encoding and level-bus field positions.
package nt_emotion_pkg;

  // Width of the packed level bus and of each neurotransmitter field
  localparam int NT_BUS_W   = 10;
  localparam int NT_FIELD_W = 2;

  // LSB position of each 2-bit level inside the packed bus
  localparam int NT_CORT_LSB = 0;
  localparam int NT_DOPA_LSB = 2;
  localparam int NT_GABA_LSB = 4;
  localparam int NT_NORE_LSB = 6;
  localparam int NT_SERO_LSB = 8;

  // Number of emotion classes; emotional_state is one-hot over these
  localparam int NT_EMO_NUM = 8;
  localparam int NT_EMO_W   = 3;

  // Emotion indices (bit position in the one-hot emotional_state)
  typedef enum logic [NT_EMO_W-1:0] {
    EMO_CALM    = 3'd0,
    EMO_HAPPY   = 3'd1,
    EMO_EXCITED = 3'd2,
    EMO_ANXIOUS = 3'd3,
    EMO_ANGRY   = 3'd4,
    EMO_SAD     = 3'd5,
    EMO_BORED   = 3'd6,
    EMO_SLEEPY  = 3'd7
  } nt_emotion_e;

  // Evaluator FSM encoding
  typedef enum logic [1:0] {
    ST_STABLE  = 2'd0,
    ST_PENDING = 2'd1,
    ST_HOLD    = 2'd2
  } nt_fsm_state_e;

  // Extract one 2-bit neurotransmitter level from the packed bus
  function automatic logic [NT_FIELD_W-1:0] nt_field(
    input logic [NT_BUS_W-1:0] bus,
    input int                  lsb
  );
    return bus[lsb +: NT_FIELD_W];
  endfunction

  // One-hot encoding of an emotion index
  function automatic logic [NT_EMO_NUM-1:0] nt_onehot(
    input logic [NT_EMO_W-1:0] idx
  );
    return NT_EMO_NUM'(1) << idx;
  endfunction

endpackage

// File: rtl/nt_emotion_classifier.sv
// Pure combinational classifier: packed neurotransmitter levels -> emotion index.
// Rules are checked in priority order; the first match wins, CALM is the fallback.
module nt_emotion_classifier
  import nt_emotion_pkg::*;
(
  input  logic [NT_BUS_W-1:0] levels,
  output logic [NT_EMO_W-1:0] emotion
);

  logic [NT_FIELD_W-1:0] cort;
  logic [NT_FIELD_W-1:0] dopa;
  logic [NT_FIELD_W-1:0] gaba;
  logic [NT_FIELD_W-1:0] nore;
  logic [NT_FIELD_W-1:0] sero;

  // Split the bus into its five levels
  always_comb begin
    cort = nt_field(levels, NT_CORT_LSB);
    dopa = nt_field(levels, NT_DOPA_LSB);
    gaba = nt_field(levels, NT_GABA_LSB);
    nore = nt_field(levels, NT_NORE_LSB);
    sero = nt_field(levels, NT_SERO_LSB);
  end

  // Priority rule table; stress responses outrank mood, mood outranks arousal
  always_comb begin
    emotion = EMO_CALM;
    if ((cort == 2'd3) && (nore >= 2'd2)) begin
      emotion = EMO_ANGRY;
    end else if ((cort >= 2'd2) && (gaba <= 2'd1)) begin
      emotion = EMO_ANXIOUS;
    end else if ((sero <= 2'd1) && (dopa <= 2'd1)) begin
      emotion = EMO_SAD;
    end else if ((dopa == 2'd3) && (nore >= 2'd2)) begin
      emotion = EMO_EXCITED;
    end else if ((dopa >= 2'd2) && (sero >= 2'd2)) begin
      emotion = EMO_HAPPY;
    end else if ((gaba == 2'd3) && (nore == 2'd0)) begin
      emotion = EMO_SLEEPY;
    end else if ((dopa == 2'd0) && (nore <= 2'd1)) begin
      emotion = EMO_BORED;
    end
  end

endmodule

// File: rtl/nt_emotion_evaluator.sv
// Reader end of the neurotransmitter level bus. Classifies the levels on each
// eval cycle (tick & level_valid), requires a new class to persist for
// PERSIST_TICKS evals before committing it, then ignores the bus for
// DWELL_TICKS evals so the mood loop cannot oscillate.
module nt_emotion_evaluator
  import nt_emotion_pkg::*;
#(
  parameter int PERSIST_TICKS = 4,
  parameter int DWELL_TICKS   = 8,
  parameter int CNT_W         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  level_valid,
  input  logic [NT_BUS_W-1:0]   neurotransmitter_level,
  output logic [NT_EMO_NUM-1:0] emotional_state,
  output logic [NT_EMO_W-1:0]   emotion_id,
  output logic                  state_changed
);

  localparam logic [CNT_W-1:0] PERSIST_MAX = CNT_W'(PERSIST_TICKS);
  localparam logic [CNT_W-1:0] DWELL_MAX   = CNT_W'(DWELL_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // ---- stage p0: qualify and classify the bus -------------------------------
  logic                  vld_p0;
  logic [NT_BUS_W-1:0]   level_p0;
  logic [NT_EMO_W-1:0]   class_p0;

  // Gate the bus so unknown levels on non-eval cycles never reach the FSM
  always_comb begin
    vld_p0   = tick & level_valid;
    level_p0 = vld_p0 ? neurotransmitter_level : '0;
  end

  nt_emotion_classifier u_classifier (
    .levels  (level_p0),
    .emotion (class_p0)
  );

  // ---- stage p1: persistence / dwell FSM and committed outputs --------------
  nt_fsm_state_e         state, state_n;
  logic [NT_EMO_W-1:0]   candidate, candidate_n;
  logic [CNT_W-1:0]      persist_cnt, persist_cnt_n;
  logic [CNT_W-1:0]      dwell_cnt, dwell_cnt_n;
  logic                  commit;
  logic [NT_EMO_W-1:0]   commit_id;

  // Next-state, counter updates and commit decision; only eval cycles move anything
  always_comb begin
    state_n       = state;
    candidate_n   = candidate;
    persist_cnt_n = persist_cnt;
    dwell_cnt_n   = dwell_cnt;
    commit        = 1'b0;
    commit_id     = emotion_id;

    if (vld_p0) begin
      case (state)
        ST_STABLE: begin
          if (class_p0 != emotion_id) begin
            candidate_n = class_p0;
            if (PERSIST_TICKS == 1) begin
              commit    = 1'b1;
              commit_id = class_p0;
            end else begin
              persist_cnt_n = CNT_ONE;
              state_n       = ST_PENDING;
            end
          end
        end

        ST_PENDING: begin
          if (class_p0 == candidate) begin
            if ((persist_cnt + CNT_ONE) == PERSIST_MAX) begin
              commit    = 1'b1;
              commit_id = candidate;
            end else begin
              persist_cnt_n = persist_cnt + CNT_ONE;
            end
          end else if (class_p0 == emotion_id) begin
            // Levels drifted back to the committed mood: abandon the candidate
            persist_cnt_n = '0;
            state_n       = ST_STABLE;
          end else begin
            // A different new class restarts the persistence window
            candidate_n   = class_p0;
            persist_cnt_n = CNT_ONE;
          end
        end

        ST_HOLD: begin
          dwell_cnt_n = dwell_cnt - CNT_ONE;
          if (dwell_cnt == CNT_ONE) begin
            state_n = ST_STABLE;
          end
        end

        default: begin
          state_n       = ST_STABLE;
          persist_cnt_n = '0;
          dwell_cnt_n   = '0;
        end
      endcase

      if (commit) begin
        persist_cnt_n = '0;
        if (DWELL_TICKS > 0) begin
          dwell_cnt_n = DWELL_MAX;
          state_n     = ST_HOLD;
        end else begin
          state_n = ST_STABLE;
        end
      end
    end
  end

  // FSM state, candidate and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_STABLE;
      candidate   <= EMO_CALM;
      persist_cnt <= '0;
      dwell_cnt   <= '0;
    end else begin
      state       <= state_n;
      candidate   <= candidate_n;
      persist_cnt <= persist_cnt_n;
      dwell_cnt   <= dwell_cnt_n;
    end
  end

  // Committed emotion registers and the one-cycle change pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      emotional_state <= nt_onehot(EMO_CALM);
      emotion_id      <= EMO_CALM;
      state_changed   <= 1'b0;
    end else begin
      state_changed <= commit;
      if (commit) begin
        emotional_state <= nt_onehot(commit_id);
        emotion_id      <= commit_id;
      end
    end
  end

endmodule

// File: tb/tb_nt_emotion_evaluator.sv
// Self-checking bench for nt_emotion_evaluator (PERSIST_TICKS=4, DWELL_TICKS=8).
// A run-length model of the mood filter is compared against the DUT every
// cycle; directed scenarios add literal expectations at key points.
module tb_nt_emotion_evaluator;

  localparam int PERSIST = 4;
  localparam int DWELL   = 8;

  localparam logic [9:0] LV_ANGRY   = 10'b10_10_10_10_11;
  localparam logic [9:0] LV_CALM    = 10'b10_01_10_01_00;
  localparam logic [9:0] LV_HAPPY   = 10'b10_01_10_10_00;
  localparam logic [9:0] LV_SAD     = 10'b00_00_00_00_00;
  localparam logic [9:0] LV_ANXIOUS = 10'b10_00_00_10_10;
  localparam logic [9:0] LV_EXCITED = 10'b10_10_10_11_00;
  localparam logic [9:0] LV_SLEEPY  = 10'b10_00_11_01_00;
  localparam logic [9:0] LV_BORED   = 10'b10_01_10_00_00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       level_valid = 1'b0;
  logic [9:0] level = '0;
  logic [7:0] emotional_state;
  logic [2:0] emotion_id;
  logic       state_changed;

  int n_checks = 0;
  int n_errors = 0;

  nt_emotion_evaluator #(
    .PERSIST_TICKS (PERSIST),
    .DWELL_TICKS   (DWELL),
    .CNT_W         (4)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .tick                   (tick),
    .level_valid            (level_valid),
    .neurotransmitter_level (level),
    .emotional_state        (emotional_state),
    .emotion_id             (emotion_id),
    .state_changed          (state_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Emotion rules straight from the priority table
  function automatic int ref_class(input logic [9:0] b);
    int c, d, g, n, s;
    c = int'(b[1:0]); d = int'(b[3:2]); g = int'(b[5:4]);
    n = int'(b[7:6]); s = int'(b[9:8]);
    if (c == 3 && n >= 2) return 4;
    if (c >= 2 && g <= 1) return 3;
    if (s <= 1 && d <= 1) return 5;
    if (d == 3 && n >= 2) return 2;
    if (d >= 2 && s >= 2) return 1;
    if (g == 3 && n == 0) return 7;
    if (d == 0 && n <= 1) return 6;
    return 0;
  endfunction

  // Model: committed mood, length of the current run of a differing class,
  // and how many eval ticks remain to be ignored after a commit.
  int m_id = 0, m_run_cls = 0, m_run_len = 0, m_hold = 0;
  bit m_sc = 1'b0, m_live = 1'b0;

  always @(posedge clk) begin
    int c;
    if (rst) begin
      m_id = 0; m_run_len = 0; m_hold = 0; m_sc = 1'b0; m_live = 1'b1;
    end else begin
      m_sc = 1'b0;
      if (tick && level_valid) begin
        if (m_hold > 0) begin
          m_hold = m_hold - 1;
        end else begin
          c = ref_class(level);
          if (c == m_id) m_run_len = 0;
          else if (m_run_len > 0 && c == m_run_cls) m_run_len = m_run_len + 1;
          else begin m_run_cls = c; m_run_len = 1; end
          if (m_run_len == PERSIST) begin
            m_id = c; m_sc = 1'b1; m_run_len = 0; m_hold = DWELL;
          end
        end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      check("emotional_state", 32'(emotional_state), 32'(8'd1 << m_id));
      check("emotion_id", 32'(emotion_id), 32'(m_id));
      check("state_changed", 32'(state_changed), 32'(m_sc));
    end
  end

  // Drive one cycle at the falling edge, return just after the rising edge
  task automatic cyc(input logic r, input logic v, input logic t, input logic [9:0] lv);
    @(negedge clk);
    rst = r; level_valid = v; tick = t; level = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [9:0] lv, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, lv);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 1'b1, LV_ANGRY);
    cyc(1'b1, 1'b1, 1'b1, LV_ANGRY);
  endtask

  // Literal expectation on both the DUT and the model
  task automatic expect_id(input string name, input int id, input bit sc);
    check({name, "_id"}, 32'(emotion_id), 32'(id));
    check({name, "_state"}, 32'(emotional_state), 32'(8'd1 << id));
    check({name, "_pulse"}, 32'(state_changed), 32'(sc));
    check({name, "_model"}, 32'(m_id), 32'(id));
  endtask

  logic [9:0] tbl_lv [8];
  int         tbl_id [8];

  initial begin
    tbl_lv = '{LV_SAD, LV_ANXIOUS, LV_EXCITED, LV_SLEEPY, LV_BORED, LV_CALM, LV_HAPPY, LV_ANGRY};
    tbl_id = '{5, 3, 2, 7, 6, 0, 1, 4};

    // Reset, with ticks present; reset wins
    do_reset();
    expect_id("reset", 0, 1'b0);

    // Commit on 4th ANGRY tick, then HAPPY straight into the dwell window
    run(LV_ANGRY, 3);
    expect_id("angry_pre", 0, 1'b0);
    run(LV_ANGRY, 1);
    expect_id("angry_commit", 4, 1'b1);
    run(LV_HAPPY, 1);
    expect_id("angry_pulse_end", 4, 1'b0);
    run(LV_HAPPY, 10);
    expect_id("dwell_11", 4, 1'b0);
    run(LV_HAPPY, 1);
    expect_id("dwell_12", 1, 1'b1);

    // Glitch reject: 3 ANGRY then CALM; count must restart afterwards
    do_reset();
    run(LV_ANGRY, 3);
    run(LV_CALM, 1);
    expect_id("glitch", 0, 1'b0);
    run(LV_CALM, 2);
    run(LV_ANGRY, 3);
    expect_id("glitch_restart_pre", 0, 1'b0);
    run(LV_ANGRY, 1);
    expect_id("glitch_restart", 4, 1'b1);

    // Gating: invalid (unknown bus) and tick-less cycles change nothing
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 10'bx);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, LV_ANGRY);
    expect_id("gated", 0, 1'b0);
    run(LV_ANGRY, 3);
    expect_id("gated_pre", 0, 1'b0);
    run(LV_ANGRY, 1);
    expect_id("gated_commit", 4, 1'b1);

    // Reset during PENDING and during HOLD
    do_reset();
    run(LV_ANGRY, 2);
    cyc(1'b1, 1'b1, 1'b1, LV_ANGRY);
    expect_id("rst_pending", 0, 1'b0);
    run(LV_ANGRY, 3);
    expect_id("rst_pending_pre", 0, 1'b0);
    run(LV_ANGRY, 1);
    expect_id("rst_pending_commit", 4, 1'b1);
    run(LV_ANGRY, 2);
    cyc(1'b1, 1'b1, 1'b1, LV_ANGRY);
    expect_id("rst_hold", 0, 1'b0);
    run(LV_ANGRY, 3);
    expect_id("rst_hold_pre", 0, 1'b0);
    run(LV_ANGRY, 1);
    expect_id("rst_hold_commit", 4, 1'b1);

    // Every classifier rule, each held long enough to commit and clear dwell
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run(tbl_lv[i], 12);
      expect_id($sformatf("class_%0d", i), tbl_id[i], 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
